fsm_state_sequencer: RTL and testbench

//  Parametrised successor of the two-state colour FSM: an N-state cyclic Moore

---
 rtl/fsm_seq_pkg.sv | 25 ++
 rtl/fsm_state_sequencer_if.sv | 28 ++
 rtl/fsm_state_sequencer_sat_counter.sv | 31 +++
 rtl/fsm_state_sequencer.sv | 74 +++++++
 tb/tb_fsm_state_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared types and the successor-index helper for the cyclic state sequencer.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD    = 2'd0,
    CMD_ADVANCE = 2'd1,
    CMD_BACK    = 2'd2,
    CMD_HOME    = 2'd3
  } seq_cmd_t;

  // Successor of cur under an explicit command; HOLD returns cur unchanged.
  function automatic int unsigned next_index(int unsigned cur, seq_cmd_t cmd,
                                             int unsigned n, int unsigned home);
    int unsigned nxt;
    nxt = cur;
    case (cmd)
      CMD_HOME:    nxt = home;
      CMD_ADVANCE: nxt = (cur == n - 1) ? 0 : cur + 1;
      CMD_BACK:    nxt = (cur == 0) ? n - 1 : cur - 1;
      default:     nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fsm_state_sequencer_if.sv
// Command/status bundle of the state sequencer; the sequencer is the slave side.
interface fsm_state_sequencer_if
  import fsm_seq_pkg::*;
#(
  parameter int unsigned NumStates = 4,
  parameter int unsigned OutWidth  = 2,
  parameter int unsigned CntWidth  = 8
) ();
  localparam int unsigned StateWidth = $clog2(NumStates);

  seq_cmd_t                cmd;
  logic [CntWidth-1:0]     timeout;
  logic [OutWidth-1:0]     out_code;
  logic [StateWidth-1:0]   state;
  logic [CntWidth-1:0]     dwell;
  logic                    wrap;
  logic [CntWidth-1:0]     home_count;

  modport master (
    output cmd, timeout,
    input  out_code, state, dwell, wrap, home_count
  );

  modport slave (
    input  cmd, timeout,
    output out_code, state, dwell, wrap, home_count
  );
endinterface

// File: rtl/fsm_state_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);
  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/fsm_state_sequencer.sv
// N-state cyclic Moore sequencer: commanded advance/back/home, dwell-timeout
// auto-advance, forward-wrap pulse and home-state occupancy count.
module fsm_state_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int unsigned NumStates = 4,
  parameter int unsigned HomeState = 1,
  parameter int unsigned OutWidth  = 2,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  fsm_state_sequencer_if.slave  bus
);
  localparam int unsigned StateWidth = $clog2(NumStates);
  typedef logic [StateWidth-1:0] state_t;

  state_t              state_q, state_d;
  logic                wrap_q, wrap_d;
  logic [CntWidth-1:0] home_cnt_q;
  logic [CntWidth-1:0] dwell;
  logic [OutWidth-1:0] out_code;
  seq_cmd_t            cmd_eff;
  logic                transition;

  // Next state: an expired dwell under HOLD behaves exactly like ADVANCE.
  always_comb begin
    cmd_eff = bus.cmd;
    if ((bus.cmd == CMD_HOLD) && (bus.timeout != '0) && (dwell == bus.timeout)) begin
      cmd_eff = CMD_ADVANCE;
    end
    state_d    = state_t'(next_index(32'(state_q), cmd_eff, NumStates, HomeState));
    transition = (state_d != state_q);
    wrap_d     = (cmd_eff == CMD_ADVANCE) && (state_q == state_t'(NumStates - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= state_t'(HomeState);
      wrap_q     <= 1'b0;
      home_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      if (state_q == state_t'(HomeState)) begin
        home_cnt_q <= home_cnt_q + 1'b1;
      end
    end
  end

  sat_counter #(
    .Width (CntWidth)
  ) u_dwell (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (transition),
    .inc_i  (1'b1),
    .cnt_o  (dwell)
  );

  // Encodings beyond NumStates-1 are unreachable and decode to 0.
  always_comb begin
    out_code = '0;
    if (32'(state_q) < NumStates) begin
      out_code = OutWidth'(32'(state_q) + 1);
    end
  end

  assign bus.out_code   = out_code;
  assign bus.state      = state_q;
  assign bus.dwell      = dwell;
  assign bus.wrap       = wrap_q;
  assign bus.home_count = home_cnt_q;
endmodule

// File: tb/tb_fsm_state_sequencer.sv
// Directed plus randomized bench for fsm_state_sequencer; three configurations
// share one command stream and are checked against an arithmetic reference model.
module tb_fsm_state_sequencer;
  import fsm_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fsm_state_sequencer_if #(.NumStates(4), .OutWidth(2), .CntWidth(8)) if0 ();
  fsm_state_sequencer_if #(.NumStates(4), .OutWidth(2), .CntWidth(3)) if1 ();
  fsm_state_sequencer_if #(.NumStates(3), .OutWidth(2), .CntWidth(8)) if2 ();

  fsm_state_sequencer #(.NumStates(4), .HomeState(1), .OutWidth(2), .CntWidth(8)) u0 (
    .clk_i (clk), .rst_ni (rst_n), .bus (if0.slave)
  );
  fsm_state_sequencer #(.NumStates(4), .HomeState(1), .OutWidth(2), .CntWidth(3)) u1 (
    .clk_i (clk), .rst_ni (rst_n), .bus (if1.slave)
  );
  fsm_state_sequencer #(.NumStates(3), .HomeState(0), .OutWidth(2), .CntWidth(8)) u2 (
    .clk_i (clk), .rst_ni (rst_n), .bus (if2.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  int m_n  [3] = '{4, 4, 3};
  int m_h  [3] = '{1, 1, 0};
  int m_cw [3] = '{8, 3, 8};
  int m_state [3];
  int m_dwell [3];
  int m_hc    [3];
  int m_wrap  [3];

  seq_cmd_t cur_cmd;
  int       cur_to;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(seq_cmd_t c, int t);
    cur_cmd = c;
    cur_to  = t;
    if0.cmd = c;  if0.timeout = 8'(t);
    if1.cmd = c;  if1.timeout = 3'(t);
    if2.cmd = c;  if2.timeout = 8'(t);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_state[i] = m_h[i];
      m_dwell[i] = 0;
      m_hc[i]    = 0;
      m_wrap[i]  = 0;
    end
  endtask

  // One clock edge of the behavioural model, from the command rules directly.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int n, s, to_i, lim, nx, fwd;
      n    = m_n[i];
      s    = m_state[i];
      lim  = (1 << m_cw[i]);
      to_i = cur_to % lim;
      nx   = s;
      fwd  = 0;
      case (cur_cmd)
        CMD_HOME:    nx = m_h[i];
        CMD_ADVANCE: begin nx = (s + 1) % n; fwd = 1; end
        CMD_BACK:    nx = (s + n - 1) % n;
        default: if (to_i != 0 && m_dwell[i] == to_i) begin nx = (s + 1) % n; fwd = 1; end
      endcase
      m_wrap[i]  = (fwd == 1 && s == n - 1) ? 1 : 0;
      m_hc[i]    = (s == m_h[i]) ? (m_hc[i] + 1) % lim : m_hc[i];
      m_dwell[i] = (nx != s) ? 0 : ((m_dwell[i] == lim - 1) ? m_dwell[i] : m_dwell[i] + 1);
      m_state[i] = nx;
    end
  endtask

  task automatic check_all(string phase);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] st, oc, dw, wr, hc;
      case (i)
        0: begin st = 32'(if0.state); oc = 32'(if0.out_code); dw = 32'(if0.dwell);
                 wr = 32'(if0.wrap); hc = 32'(if0.home_count); end
        1: begin st = 32'(if1.state); oc = 32'(if1.out_code); dw = 32'(if1.dwell);
                 wr = 32'(if1.wrap); hc = 32'(if1.home_count); end
        default: begin st = 32'(if2.state); oc = 32'(if2.out_code); dw = 32'(if2.dwell);
                 wr = 32'(if2.wrap); hc = 32'(if2.home_count); end
      endcase
      check($sformatf("%s.u%0d.state", phase, i), st, 32'(m_state[i]));
      check($sformatf("%s.u%0d.out", phase, i), oc, 32'((m_state[i] + 1) % 4));
      check($sformatf("%s.u%0d.dwell", phase, i), dw, 32'(m_dwell[i]));
      check($sformatf("%s.u%0d.wrap", phase, i), wr, 32'(m_wrap[i]));
      check($sformatf("%s.u%0d.home_count", phase, i), hc, 32'(m_hc[i]));
    end
    check($sformatf("%s.u2.range", phase), 32'(if2.state < 2'd3), 32'd1);
  endtask

  task automatic tick(string phase);
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all(phase);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(CMD_HOLD, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    check_all("release");
    check("t1.state", 32'(if0.state), 32'd1);
    check("t1.out", 32'(if0.out_code), 32'd2);
    repeat (3) tick("t1");
    check("t1.dwell3", 32'(if0.dwell), 32'd3);
    check("t1.home3", 32'(if0.home_count), 32'd3);

    set_in(CMD_ADVANCE, 0);
    tick("t2");
    check("t2.s2", 32'(if0.state), 32'd2);
    check("t2.o3", 32'(if0.out_code), 32'd3);
    check("t2.w0a", 32'(if0.wrap), 32'd0);
    tick("t2");
    check("t2.s3", 32'(if0.state), 32'd3);
    check("t2.o0", 32'(if0.out_code), 32'd0);
    tick("t2");
    check("t2.s0", 32'(if0.state), 32'd0);
    check("t2.o1", 32'(if0.out_code), 32'd1);
    check("t2.w1", 32'(if0.wrap), 32'd1);

    set_in(CMD_BACK, 0);
    tick("t3");
    check("t3.back", 32'(if0.state), 32'd3);
    check("t3.nowrap", 32'(if0.wrap), 32'd0);
    set_in(CMD_HOME, 0);
    tick("t3");
    check("t3.home", 32'(if0.state), 32'd1);
    check("t3.dw0", 32'(if0.dwell), 32'd0);
    tick("t3");
    check("t3.dw1", 32'(if0.dwell), 32'd1);

    set_in(CMD_ADVANCE, 5);
    tick("t4");
    set_in(CMD_HOME, 5);
    tick("t4");
    set_in(CMD_HOLD, 5);
    repeat (5) tick("t4");
    check("t4.still1", 32'(if0.state), 32'd1);
    check("t4.dw5", 32'(if0.dwell), 32'd5);
    tick("t4");
    check("t4.auto", 32'(if0.state), 32'd2);
    repeat (3) tick("t4");
    set_in(CMD_HOLD, 0);
    repeat (10) tick("t4");
    check("t4.noauto", 32'(if0.state), 32'd2);
    check("t4.dw13", 32'(if0.dwell), 32'd13);
    check("t4.sat7", 32'(if1.dwell), 32'd7);

    set_in(CMD_HOME, 2);
    tick("t5");
    set_in(CMD_HOLD, 2);
    repeat (2) tick("t5");
    set_in(CMD_ADVANCE, 2);
    tick("t5");
    check("t5.single", 32'(if0.state), 32'd2);
    set_in(CMD_ADVANCE, 0);
    repeat (2) tick("t5");
    check("t5.wrapset", 32'(if0.wrap), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("t5rst");
    check("t5.rwrap", 32'(if0.wrap), 32'd0);
    check("t5.rstate", 32'(if0.state), 32'd1);
    check("t5.rhome", 32'(if0.home_count), 32'd0);
    @(negedge clk);
    check_all("t5hold");
    rst_n = 1'b1;

    for (int k = 0; k < 600; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      case (r)
        5, 6, 9: set_in(CMD_ADVANCE, int'($urandom_range(0, 7)));
        7:       set_in(CMD_BACK, int'($urandom_range(0, 7)));
        8:       set_in(CMD_HOME, int'($urandom_range(0, 7)));
        default: set_in(CMD_HOLD, int'($urandom_range(0, 7)));
      endcase
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        tick("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
